iq_phase_detector: RTL

Inverse of the NCO: takes one signed 8-bit sine/cosine (Q/I) sample pair and recovers its phase and magnitude. The phase is expressed in the NCO accumulator format, where a full turn is 2^32. The block is an iterative CORDIC vectoring engine with valid/ready handshakes on input and output. It sits downstream of the NCO or an external I/Q source, and is used for phase measurement and NCO loop-back checking.

---
 rtl/iq_pkg.sv | 15 +
 rtl/cordic_vec_stage.sv | 30 +++
 rtl/iq_phase_detector.sv | 109 ++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// Shared constants for the I/Q phase detector: arctangent table, widths, FSM states.
package iq_pkg;
  localparam int PHASE_W  = 32;
  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_e;

  // atan(2^-i) scaled so that a full turn is 2^32
  localparam logic [PHASE_W-1:0] ATAN [16] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D
  };
endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational CORDIC vectoring micro-rotation driving y toward zero.
module cordic_vec_stage
  import iq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0]       i_x,
  input  logic signed [W-1:0]       i_y,
  input  logic        [PHASE_W-1:0] i_z,
  input  logic        [3:0]         i_idx,
  output logic signed [W-1:0]       o_x,
  output logic signed [W-1:0]       o_y,
  output logic        [PHASE_W-1:0] o_z
);
  logic signed [W-1:0] w_xs, w_ys;

  always_comb begin
    w_xs = i_x >>> i_idx;
    w_ys = i_y >>> i_idx;
    if (!i_y[W-1]) begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + ATAN[i_idx];
    end else begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - ATAN[i_idx];
    end
  end
endmodule

// File: rtl/iq_phase_detector.sv
// Iterative CORDIC vectoring engine: (Q, I) sample pair -> phase (2^32 per turn) and magnitude.
module iq_phase_detector
  import iq_pkg::*;
#(
  parameter int ITERS = 12,
  parameter int FRAC  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] sin_in,
  input  logic [SAMPLE_W-1:0] cos_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PHASE_W-1:0]  phase_out,
  output logic [9:0]          mag_out
);
  localparam int W     = 10 + FRAC;
  localparam int CNT_W = 5;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic signed [W-1:0] r_x, r_y;
  logic [PHASE_W-1:0]  r_z;
  logic                r_zero;
  logic [PHASE_W-1:0]  r_phase;
  logic [9:0]          r_mag;

  logic signed [W-1:0] w_cx, w_cy, w_nx, w_ny;
  logic [PHASE_W-1:0]  w_nz;
  logic                w_last;

  // Two extra integer bits let -128 negate cleanly during pre-rotation
  assign w_cx   = {{(W-SAMPLE_W){cos_in[SAMPLE_W-1]}}, cos_in} <<< FRAC;
  assign w_cy   = {{(W-SAMPLE_W){sin_in[SAMPLE_W-1]}}, sin_in} <<< FRAC;
  assign w_last = (r_cnt == CNT_W'(ITERS));

  cordic_vec_stage #(.W(W)) u_stage (
    .i_x  (r_x),
    .i_y  (r_y),
    .i_z  (r_z),
    .i_idx(r_cnt[3:0]),
    .o_x  (w_nx),
    .o_y  (w_ny),
    .o_z  (w_nz)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_ITER;
      ST_ITER: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Counter runs 0..ITERS: ITERS rotations, then one cycle to register the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_zero  <= 1'b0;
      r_phase <= '0;
      r_mag   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_cnt  <= '0;
          r_zero <= (sin_in == '0) && (cos_in == '0);
          if (cos_in[SAMPLE_W-1]) begin
            r_x <= -w_cx;
            r_y <= -w_cy;
            r_z <= 32'h8000_0000;
          end else begin
            r_x <= w_cx;
            r_y <= w_cy;
            r_z <= '0;
          end
        end
        ST_ITER: begin
          if (w_last) begin
            r_phase <= r_zero ? '0 : r_z;
            r_mag   <= r_zero ? '0 : r_x[FRAC+9:FRAC];
          end else begin
            r_x   <= w_nx;
            r_y   <= w_ny;
            r_z   <= w_nz;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign phase_out = r_phase;
  assign mag_out   = r_mag;
endmodule
